alu_share_arbiter: RTL

- Shares the single combinational ALU datapath between two requesters, e.g. a main-datapath port and a branch-compare/address-calc port.
- Round-robin arbitration; valid/ready request and response handshakes; operands and result are registered.
- Sits between the requesters and the ALU: it drives the ALU operand and control inputs, and samples the ALU result and zero flag.

---
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one combinational ALU between two requesters.
//   - Grants are round-robin. Building with ALU_ARB_FIXED_PRIO_EN defined
//     makes requester 0 always win instead.
//   - Requests and responses use valid/ready handshakes.
//   - Only one operation is in flight at a time. Operands and the result are
//     registered.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 wins ties
//                          undefined -> round-robin (default)
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous, active-low reset
//   req{0,1}_valid/ready   request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/b/ctrl      request operands and ALU control code
//   rsp{0,1}_valid/ready   response handshake
//   rsp_result/rsp_zero    registered ALU result and zero flag (shared)
//   alu_a/alu_b/alu_ctrl   registered drive to the external ALU
//   alu_result/alu_zero    external ALU outputs, sampled in EXEC
//   busy                   high whenever the FSM is not IDLE
//
// States:
//   IDLE | waiting for a request; arbitration and accept happen here
//   EXEC | ALU driven from the operand registers; result sampled at the edge
//   RESP | result presented to the granted requester until it is taken
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_id_q, grant_id_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d;
  logic [WIDTH-1:0]    op_b_q, op_b_d;
  logic [CTRL_W-1:0]   op_ctrl_q, op_ctrl_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                rr_ptr_q, rr_ptr_d;
`endif

  logic any_valid;
  logic grant_sel;   // requester that would be granted this cycle
  logic rsp_fire;

  // Arbitration: a lone valid requester always wins; ties go to rr_ptr
  // (or to requester 0 in the fixed-priority build).
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_sel = ~req0_valid;
`else
    grant_sel = (req0_valid & req1_valid) ? rr_ptr_q : ~req0_valid;
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp_fire     = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is only raised toward a valid, granted requester, so raising
        // it is itself the handshake.
        if (any_valid) begin
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          grant_id_d = grant_sel;
          op_a_d     = grant_sel ? req1_a    : req0_a;
          op_b_d     = grant_sel ? req1_b    : req0_b;
          op_ctrl_d  = grant_sel ? req1_ctrl : req0_ctrl;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        rsp0_valid = ~grant_id_q;
        rsp1_valid = grant_id_q;
        rsp_fire   = grant_id_q ? rsp1_ready : rsp0_ready;
        if (rsp_fire) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_ptr_d = ~grant_id_q;
`endif
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  // The ALU sees only the operand registers. They keep the last operation's
  // values outside EXEC, which is harmless for a combinational ALU.
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_ctrl   = op_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);

endmodule
